// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters, registered syncs, display enable and line/frame strobes.
// Optional prefetch outputs (one-tick-ahead pixel address) enabled by defining VGA_TIMING_PREFETCH_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 1,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          HSync,
  output logic          VSync,
  output logic          output_en,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_PREFETCH_EN
  ,
  output logic [HW-1:0] fetch_x,
  output logic [VW-1:0] fetch_y,
  output logic          fetch_en
`endif
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic          HS_ON    = (HSYNC_POL != 0);
  localparam logic          VS_ON    = (VSYNC_POL != 0);

  logic [DW-1:0] divCnt;
  logic          tick;
  logic [HW-1:0] hNext;
  logic [VW-1:0] vNext;

  function automatic logic [HW-1:0] stepH(input logic [HW-1:0] h);
    return (h == H_LAST) ? '0 : h + 1'b1;
  endfunction

  // Vertical position only advances on the column that wraps the line.
  function automatic logic [VW-1:0] stepV(input logic [HW-1:0] h, input logic [VW-1:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? '0 : v + 1'b1;
  endfunction

  function automatic logic hsyncLevel(input logic [HW-1:0] h);
    logic act;
    act = (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
    return act ? HS_ON : ~HS_ON;
  endfunction

  function automatic logic vsyncLevel(input logic [VW-1:0] v);
    logic act;
    act = (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
    return act ? VS_ON : ~VS_ON;
  endfunction

  function automatic logic activeOf(input logic [HW-1:0] h, input logic [VW-1:0] v);
    return (int'(h) < H_ACTIVE) && (int'(v) < V_ACTIVE);
  endfunction

  always_comb begin
    tick  = (divCnt == DIV_LAST);
    hNext = stepH(hcount);
    vNext = stepV(hcount, vcount);
  end

  // Decode from the next-state counters so syncs and enable land on the same edge as the counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divCnt      <= '0;
      hcount      <= H_LAST;
      vcount      <= V_LAST;
      HSync       <= ~HS_ON;
      VSync       <= ~VS_ON;
      output_en   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      divCnt      <= tick ? '0 : divCnt + 1'b1;
      line_start  <= tick && (hNext == '0);
      frame_start <= tick && (hNext == '0) && (vNext == '0);
      if (tick) begin
        hcount    <= hNext;
        vcount    <= vNext;
        HSync     <= hsyncLevel(hNext);
        VSync     <= vsyncLevel(vNext);
        output_en <= activeOf(hNext, vNext);
      end
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  // Runs one pixel ahead of hcount/vcount to cover a single-cycle framebuffer read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_x  <= '0;
      fetch_y  <= '0;
      fetch_en <= 1'b1;
    end else if (tick) begin
      fetch_x  <= stepH(fetch_x);
      fetch_y  <= stepV(fetch_x, fetch_y);
      fetch_en <= activeOf(stepH(fetch_x), stepV(fetch_x, fetch_y));
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 mode, a tiny 8x6 mode, and the tiny mode at CLK_DIV=2.
// Prefetch checks are compiled in only when VGA_TIMING_PREFETCH_EN is defined.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rstAC_n;
  logic rstB_n;

  logic [9:0] hA, vA;
  logic       hsA, vsA, oeA, lsA, fsA;
  logic [2:0] hB, vB;
  logic       hsB, vsB, oeB, lsB, fsB;
  logic [2:0] hC, vC;
  logic       hsC, vsC, oeC, lsC, fsC;
`ifdef VGA_TIMING_PREFETCH_EN
  logic [9:0] fxA, fyA;
  logic       feA;
  logic [2:0] fxB, fyB, fxC, fyC;
  logic       feB, feC;
`endif

  int totalChecks = 0;
  int badChecks   = 0;
  int k           = 0;

  always #5 clk = ~clk;

  vga_timing_gen dutA (
    .clk(clk), .reset_n(rstAC_n), .hcount(hA), .vcount(vA), .HSync(hsA), .VSync(vsA),
    .output_en(oeA), .line_start(lsA), .frame_start(fsA)
`ifdef VGA_TIMING_PREFETCH_EN
    , .fetch_x(fxA), .fetch_y(fyA), .fetch_en(feA)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(1)
  ) dutB (
    .clk(clk), .reset_n(rstB_n), .hcount(hB), .vcount(vB), .HSync(hsB), .VSync(vsB),
    .output_en(oeB), .line_start(lsB), .frame_start(fsB)
`ifdef VGA_TIMING_PREFETCH_EN
    , .fetch_x(fxB), .fetch_y(fyB), .fetch_en(feB)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(1), .CLK_DIV(2)
  ) dutC (
    .clk(clk), .reset_n(rstAC_n), .hcount(hC), .vcount(vC), .HSync(hsC), .VSync(vsC),
    .output_en(oeC), .line_start(lsC), .frame_start(fsC)
`ifdef VGA_TIMING_PREFETCH_EN
    , .fetch_x(fxC), .fetch_y(fyC), .fetch_en(feC)
`endif
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s at k=%0d: got %0d expected %0d", tag, k, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ac, input logic b);
    rstAC_n = ac;
    rstB_n  = b;
  endtask

  // k counts rising edges since reset release; outputs are sampled on the falling edge.
  task automatic advanceTo(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0);
    repeat (3) @(negedge clk);

    checkOutput("A rst hcount", hA, 799);
    checkOutput("A rst vcount", vA, 524);
    checkOutput("A rst HSync", hsA, 1);
    checkOutput("A rst VSync", vsA, 1);
    checkOutput("A rst output_en", oeA, 0);
    checkOutput("A rst line_start", lsA, 0);
    checkOutput("A rst frame_start", fsA, 0);
    checkOutput("B rst hcount", hB, 7);
    checkOutput("B rst vcount", vB, 5);
    checkOutput("B rst HSync", hsB, 0);
    checkOutput("B rst VSync", vsB, 0);
    checkOutput("C rst hcount", hC, 7);
`ifdef VGA_TIMING_PREFETCH_EN
    checkOutput("A rst fetch_x", fxA, 0);
    checkOutput("A rst fetch_y", fyA, 0);
    checkOutput("A rst fetch_en", feA, 1);
`endif

    applyStimulus(1'b1, 1'b1);

    advanceTo(1);
    checkOutput("A first hcount", hA, 0);
    checkOutput("A first vcount", vA, 0);
    checkOutput("A first frame_start", fsA, 1);
    checkOutput("A first line_start", lsA, 1);
    checkOutput("A first output_en", oeA, 1);
    checkOutput("A first HSync", hsA, 1);
    checkOutput("B first frame_start", fsB, 1);
    checkOutput("C no tick hcount", hC, 7);
    checkOutput("C no tick frame_start", fsC, 0);
`ifdef VGA_TIMING_PREFETCH_EN
    checkOutput("A first fetch_x", fxA, 1);
    checkOutput("A first fetch_y", fyA, 0);
`endif

    advanceTo(2);
    checkOutput("A k2 hcount", hA, 1);
    checkOutput("A k2 frame_start", fsA, 0);
    checkOutput("A k2 line_start", lsA, 0);
    checkOutput("C first hcount", hC, 0);
    checkOutput("C first vcount", vC, 0);
    checkOutput("C first frame_start", fsC, 1);
    checkOutput("C first line_start", lsC, 1);

    advanceTo(3);
    checkOutput("C hold hcount", hC, 0);
    checkOutput("C pulse width frame_start", fsC, 0);
    checkOutput("C pulse width line_start", lsC, 0);

    advanceTo(4);
    checkOutput("B h3 hcount", hB, 3);
    checkOutput("B h3 output_en", oeB, 1);
    checkOutput("C k4 hcount", hC, 1);
    advanceTo(5);
    checkOutput("B h4 output_en", oeB, 0);
    checkOutput("B h4 HSync", hsB, 0);
    checkOutput("C k5 hcount", hC, 1);
    advanceTo(6);
    checkOutput("B h5 HSync", hsB, 1);
    advanceTo(7);
    checkOutput("B h6 HSync", hsB, 1);
    advanceTo(8);
    checkOutput("B h7 HSync", hsB, 0);

    advanceTo(32);
    checkOutput("B v3 vcount", vB, 3);
    checkOutput("B v3 VSync", vsB, 0);
    advanceTo(33);
    checkOutput("B v4 VSync", vsB, 1);
    checkOutput("B v4 line_start", lsB, 1);
    checkOutput("B v4 hcount", hB, 0);
    advanceTo(41);
    checkOutput("B v5 VSync", vsB, 0);

    advanceTo(48);
    checkOutput("B end hcount", hB, 7);
    checkOutput("B end vcount", vB, 5);
    checkOutput("B end frame_start", fsB, 0);
`ifdef VGA_TIMING_PREFETCH_EN
    checkOutput("B wrap fetch_x", fxB, 0);
    checkOutput("B wrap fetch_y", fyB, 0);
    checkOutput("B wrap fetch_en", feB, 1);
`endif
    advanceTo(49);
    checkOutput("B 2nd frame_start", fsB, 1);
    checkOutput("B 2nd hcount", hB, 0);
    checkOutput("B 2nd vcount", vB, 0);

    advanceTo(60);
    checkOutput("B pre-abort hcount", hB, 3);
    checkOutput("B pre-abort vcount", vB, 1);
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("B abort hcount", hB, 7);
    checkOutput("B abort vcount", vB, 5);
    checkOutput("B abort output_en", oeB, 0);
    advanceTo(61);
    checkOutput("B held hcount", hB, 7);
    applyStimulus(1'b1, 1'b1);
    advanceTo(62);
    checkOutput("B restart hcount", hB, 0);
    checkOutput("B restart frame_start", fsB, 1);

    advanceTo(97);
    checkOutput("C end frame_start", fsC, 0);
    checkOutput("C end hcount", hC, 7);
    checkOutput("C end vcount", vC, 5);
    advanceTo(98);
    checkOutput("C 2nd frame_start", fsC, 1);
    checkOutput("C 2nd hcount", hC, 0);
    advanceTo(99);
    checkOutput("C 2nd pulse width", fsC, 0);

    advanceTo(640);
    checkOutput("A h639 hcount", hA, 639);
    checkOutput("A h639 output_en", oeA, 1);
    advanceTo(641);
    checkOutput("A h640 output_en", oeA, 0);
    advanceTo(656);
    checkOutput("A h655 hcount", hA, 655);
    checkOutput("A h655 HSync", hsA, 1);
    advanceTo(657);
    checkOutput("A h656 HSync", hsA, 0);
    advanceTo(752);
    checkOutput("A h751 HSync", hsA, 0);
    advanceTo(753);
    checkOutput("A h752 HSync", hsA, 1);
    checkOutput("A h752 output_en", oeA, 0);

    advanceTo(800);
    checkOutput("A h799 hcount", hA, 799);
    checkOutput("A h799 line_start", lsA, 0);
`ifdef VGA_TIMING_PREFETCH_EN
    checkOutput("A h799 fetch_x", fxA, 0);
    checkOutput("A h799 fetch_y", fyA, 1);
`endif
    advanceTo(801);
    checkOutput("A line1 hcount", hA, 0);
    checkOutput("A line1 vcount", vA, 1);
    checkOutput("A line1 line_start", lsA, 1);
    checkOutput("A line1 frame_start", fsA, 0);
    checkOutput("A line1 VSync", vsA, 1);
    checkOutput("A line1 output_en", oeA, 1);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
